// File: rtl/profiler_pkg.sv
// Shared types and constants for the profiler snapshot streamer.
// The checksum byte is enabled by defining PROFILER_SNAPSHOT_CHECKSUM_EN.
package profiler_pkg;

  localparam logic [7:0] FRAME_HEADER = 8'hA5;
  localparam int DEFAULT_NUM_COUNTERS = 9;
  localparam int COUNTER_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    SEQ,
    DATA,
    CSUM
  } snapshot_state_t;

endpackage

// File: rtl/profiler_snapshot_streamer_timer.sv
// Free-running sample period timer; emits a one-cycle tick each period.
// Held at zero while enable is low.
module period_timer #(
  parameter int SAMPLE_PERIOD = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tick
);

  localparam int CW = $clog2(SAMPLE_PERIOD);
  localparam logic [CW-1:0] LAST = CW'(SAMPLE_PERIOD - 1);

  logic [CW-1:0] count;

  assign tick = enable && (count == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (!enable || tick) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/profiler_snapshot_streamer.sv
// Captures profiler counters every sample period and streams them as a
// framed byte sequence. Checksum byte: PROFILER_SNAPSHOT_CHECKSUM_EN.
module profiler_snapshot_streamer
  import profiler_pkg::*;
#(
  parameter int SAMPLE_PERIOD = 1000000,
  parameter int NUM_COUNTERS  = DEFAULT_NUM_COUNTERS
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              enable,
  input  logic [NUM_COUNTERS*COUNTER_W-1:0] counters,
  output logic [7:0]                        tx_data,
  output logic                              tx_valid,
  input  logic                              tx_ready,
  output logic                              busy,
  output logic [7:0]                        frame_seq,
  output logic [15:0]                       overrun_count
);

  localparam int NB = 4 * NUM_COUNTERS;
  localparam int IW = $clog2(NB);
  localparam int BW = NUM_COUNTERS * COUNTER_W;
  localparam logic [IW-1:0] LAST_IDX = IW'(NB - 1);

  snapshot_state_t state, state_n;

  logic [BW-1:0] bank;
  logic [IW-1:0] idx, idx_n, idx_nx;
  logic [7:0]    data_n, seq_cnt, seq_n, fseq_n;
  logic [15:0]   ovr_n;
  logic          valid_n, load, tick, xfer;

  period_timer #(
    .SAMPLE_PERIOD(SAMPLE_PERIOD)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .enable(enable),
    .tick  (tick)
  );

  assign xfer   = tx_valid && tx_ready;
  assign busy   = (state != IDLE);
  assign idx_nx = (idx == LAST_IDX) ? '0 : idx + IW'(1);

`ifdef PROFILER_SNAPSHOT_CHECKSUM_EN
  logic [7:0] sum, sum_n, sum_all;

  // Running sum includes the byte transferring this cycle.
  assign sum_all = sum + tx_data;

  always_comb begin
    sum_n = sum;
    if (load) begin
      sum_n = '0;
    end else if (xfer) begin
      sum_n = sum_all;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum <= '0;
    end else begin
      sum <= sum_n;
    end
  end
`endif

  always_comb begin
    state_n = state;
    idx_n   = idx;
    data_n  = tx_data;
    valid_n = tx_valid;
    seq_n   = seq_cnt;
    fseq_n  = frame_seq;
    ovr_n   = overrun_count;
    load    = 1'b0;

    if (tick) begin
      if (state == IDLE) begin
        load    = 1'b1;
        state_n = HEADER;
        idx_n   = '0;
        valid_n = 1'b1;
        data_n  = FRAME_HEADER;
      end else if (overrun_count != 16'hFFFF) begin
        ovr_n = overrun_count + 16'd1;
      end
    end

    unique case (state)
      IDLE: begin
      end
      HEADER: begin
        if (xfer) begin
          state_n = SEQ;
          data_n  = seq_cnt;
          fseq_n  = seq_cnt;
          seq_n   = seq_cnt + 8'd1;
        end
      end
      SEQ: begin
        if (xfer) begin
          state_n = DATA;
          idx_n   = '0;
          data_n  = bank[7:0];
        end
      end
      DATA: begin
        if (xfer) begin
          if (idx == LAST_IDX) begin
`ifdef PROFILER_SNAPSHOT_CHECKSUM_EN
            state_n = CSUM;
            data_n  = 8'd0 - sum_all;
`else
            state_n = IDLE;
            valid_n = 1'b0;
`endif
          end else begin
            idx_n  = idx_nx;
            data_n = bank[8*int'(idx_nx) +: 8];
          end
        end
      end
      CSUM: begin
        if (xfer) begin
          state_n = IDLE;
          valid_n = 1'b0;
        end
      end
      default: begin
        state_n = IDLE;
        valid_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      idx           <= '0;
      tx_data       <= '0;
      tx_valid      <= 1'b0;
      seq_cnt       <= '0;
      frame_seq     <= '0;
      overrun_count <= '0;
    end else begin
      state         <= state_n;
      idx           <= idx_n;
      tx_data       <= data_n;
      tx_valid      <= valid_n;
      seq_cnt       <= seq_n;
      frame_seq     <= fseq_n;
      overrun_count <= ovr_n;
    end
  end

  // Bank only moves on an accepted tick so each frame is coherent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank <= '0;
    end else if (load) begin
      bank <= counters;
    end
  end

endmodule

// File: tb/tb_profiler_snapshot_streamer.sv
// Randomized scoreboard bench for profiler_snapshot_streamer.
// Honours PROFILER_SNAPSHOT_CHECKSUM_EN when computing expected frames.
module tb_profiler_snapshot_streamer;

  localparam int P  = 16;
  localparam int N  = 9;
  localparam int NB = 4 * N;
`ifdef PROFILER_SNAPSHOT_CHECKSUM_EN
  localparam int FL = NB + 3;
`else
  localparam int FL = NB + 2;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           enable;
  logic           tx_ready;
  logic [N*32-1:0] counters;
  logic [7:0]     tx_data;
  logic           tx_valid;
  logic           busy;
  logic [7:0]     frame_seq;
  logic [15:0]    overrun_count;

  logic [31:0] cv [N];

  always_comb begin
    counters = '0;
    for (int k = 0; k < N; k++) counters[32*k +: 32] = cv[k];
  end

  always #5 clk = ~clk;

  profiler_snapshot_streamer #(
    .SAMPLE_PERIOD(P),
    .NUM_COUNTERS (N)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .counters     (counters),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .busy         (busy),
    .frame_seq    (frame_seq),
    .overrun_count(overrun_count)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: frames are lists of expected bytes; rem counts
  // bytes of the current frame not yet handed to the sink.
  logic [7:0] exp_q [$];
  logic [7:0] got [$];
  int tcnt, rem, ovr, seq_ctr, cur_seq, fseq;
  bit tk, xf;

  task automatic push_frame();
    int s;
    logic [7:0] b;
    s = 'hA5 + seq_ctr;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'(seq_ctr));
    for (int k = 0; k < N; k++) begin
      for (int j = 0; j < 4; j++) begin
        b = 8'((cv[k] >> (8 * j)) & 32'hFF);
        exp_q.push_back(b);
        s += int'(b);
      end
    end
`ifdef PROFILER_SNAPSHOT_CHECKSUM_EN
    exp_q.push_back(8'((256 - (s % 256)) % 256));
`endif
    cur_seq = seq_ctr;
    seq_ctr = (seq_ctr + 1) % 256;
    rem = FL;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt = 0; rem = 0; ovr = 0;
      seq_ctr = 0; cur_seq = 0; fseq = 0;
      exp_q.delete();
    end else begin
      tk = enable && (tcnt == P - 1);
      xf = (rem > 0) && tx_ready;
      if (xf && rem == FL) fseq = cur_seq;
      if (tk) begin
        if (rem == 0) push_frame();
        else if (ovr < 65535) ovr++;
      end
      if (xf) rem--;
      tcnt = (!enable || tk) ? 0 : tcnt + 1;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_tx_valid", int'(tx_valid), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_tx_data", int'(tx_data), 0);
    end else begin
      chk("tx_valid", int'(tx_valid), int'(rem > 0));
      chk("busy", int'(busy), int'(rem > 0));
      chk("overrun_count", int'(overrun_count), ovr);
      chk("frame_seq", int'(frame_seq), fseq);
      if (tx_valid) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_byte: got %h, required no byte", tx_data);
        end else begin
          chk("tx_data", int'(tx_data), int'(exp_q[0]));
          if (tx_ready) begin
            got.push_back(tx_data);
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_cycle(inout int stall);
    if (stall > 0) begin
      tx_ready = 1'b0;
      stall--;
    end else begin
      tx_ready = ($urandom % 10) < 7;
      if ($urandom % 200 == 0) stall = 40;
    end
    if ($urandom % 300 == 0) enable = ~enable;
    else if (!enable && $urandom % 20 == 0) enable = 1'b1;
    if ($urandom % 4 == 0) cv[$urandom % N] = $urandom;
    step();
  endtask

  initial begin
    int stall;
    int waited;
    stall = 0;
    rst = 1'b1;
    enable = 1'b0;
    tx_ready = 1'b0;
    for (int k = 0; k < N; k++) cv[k] = 32'(k + 1);
    repeat (3) step();
    chk("reset_frame_seq", int'(frame_seq), 0);
    chk("reset_overrun", int'(overrun_count), 0);
    rst = 1'b0;
    step();

    // Directed frame: counters k+1, sink always ready.
    got.delete();
    tx_ready = 1'b1;
    enable = 1'b1;
    repeat (100) step();
    chk("dirA_byte_count_ok", int'(got.size() >= 40), 1);
    if (got.size() >= 40) begin
      chk("dirA_header", int'(got[0]), 'hA5);
      chk("dirA_seq0", int'(got[1]), 0);
      for (int i = 0; i < NB; i++)
        chk("dirA_data", int'(got[2+i]), (i % 4 == 0) ? i / 4 + 1 : 0);
      chk("dirA_next_header", int'(got[FL]), 'hA5);
      chk("dirA_next_seq", int'(got[FL+1]), 1);
    end

    // Randomized traffic with stalls, enable drops and counter churn.
    repeat (3000) rand_cycle(stall);

    // Reset in the middle of a frame.
    waited = 0;
    enable = 1'b1;
    while (rem != FL - 10 && waited < 400) begin
      tx_ready = $urandom % 2;
      step();
      waited++;
    end
    chk("midframe_reached", int'(rem == FL - 10), 1);
    rst = 1'b1;
    #1;
    chk("midrst_tx_valid", int'(tx_valid), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_frame_seq", int'(frame_seq), 0);
    chk("midrst_overrun", int'(overrun_count), 0);
    repeat (2) step();
    rst = 1'b0;
    stall = 0;
    repeat (800) rand_cycle(stall);

    // Drain.
    enable = 1'b0;
    tx_ready = 1'b1;
    repeat (FL + 10) step();
    chk("drain_queue_empty", exp_q.size(), 0);
    chk("drain_idle", int'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
